// File: rtl/rr_port_alloc.sv
// rr_port_alloc: wormhole output-port allocator with round-robin arbitration.
// A packet that wins the port keeps it until its tail flit actually transfers.
// The priority pointer then moves one past the released owner.
module rr_port_alloc #(
   parameter  int NR = 5,
   localparam int IW = (NR > 1) ? $clog2(NR) : 1
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic [NR-1:0] REQ,
   input  logic [NR-1:0] TAIL,
   input  logic          CRD_OK,
   output logic [NR-1:0] GRT,
   output logic          XFER,
   output logic [IW-1:0] OWNER,
   output logic          BUSY
);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] sel;
   logic          sel_found;
   logic [NR-1:0] sel_onehot;
   logic [IW-1:0] ptr_after;
   logic          release_now;

   // Circular first-set search over REQ, starting at the priority pointer.
   always_comb begin
      int idx;
      sel       = '0;
      sel_found = 1'b0;
      idx       = 0;
      for (int k = 0; k < NR; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NR) idx = idx - NR;
         if (!sel_found && REQ[idx]) begin
            sel_found = 1'b1;
            sel       = IW'(idx);
         end
      end
      sel_onehot      = '0;
      sel_onehot[sel] = 1'b1;
   end

   // Transfer qualification and release decision for the current owner.
   always_comb begin
      XFER        = BUSY & REQ[OWNER] & CRD_OK;
      release_now = XFER & TAIL[OWNER];
      ptr_after   = (OWNER == IW'(NR - 1)) ? '0 : OWNER + 1'b1;
   end

   // Allocation FSM: IDLE arbitrates, LOCK holds the port until the tail transfers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= IDLE;
         GRT   <= '0;
         OWNER <= '0;
         BUSY  <= 1'b0;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  state <= LOCK;
                  GRT   <= sel_onehot;
                  OWNER <= sel;
                  BUSY  <= 1'b1;
               end
            end
            LOCK: begin
               if (release_now) begin
                  state <= IDLE;
                  GRT   <= '0;
                  OWNER <= '0;
                  BUSY  <= 1'b0;
                  ptr   <= ptr_after;
               end
            end
            default: begin
               state <= IDLE;
               GRT   <= '0;
               OWNER <= '0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_port_alloc.sv
// tb_rr_port_alloc: scoreboard bench for rr_port_alloc (NR=5).
// The driver pushes the expected per-cycle outputs from a packet-level model;
// a monitor on the falling edge pops and compares, and checks invariants.
module tb_rr_port_alloc;
   localparam int NR = 5;
   localparam int IW = 3;

   typedef struct packed {
      logic [NR-1:0] grt;
      logic [IW-1:0] owner;
      logic          busy;
      logic          xfer;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic [NR-1:0] REQ = '0;
   logic [NR-1:0] TAIL = '0;
   logic          CRD_OK = 1'b0;
   logic [NR-1:0] GRT;
   logic          XFER;
   logic [IW-1:0] OWNER;
   logic          BUSY;

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];

   // reference model: who holds the port and where the priority starts
   bit   m_busy  = 0;
   int   m_owner = 0;
   int   m_ptr   = 0;

   rr_port_alloc #(.NR(NR)) dut (
      .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .TAIL(TAIL), .CRD_OK(CRD_OK),
      .GRT(GRT), .XFER(XFER), .OWNER(OWNER), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One clock cycle of stimulus: drive inputs, record expectations, advance model.
   task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] t, input logic c);
      exp_t e;
      @(posedge CLK);
      #1;
      RSTn = 1'b1; REQ = r; TAIL = t; CRD_OK = c;
      e.busy  = m_busy;
      e.owner = m_busy ? IW'(m_owner) : '0;
      e.grt   = m_busy ? NR'(1 << m_owner) : '0;
      e.xfer  = m_busy && r[m_owner] && c;
      sbq.push_back(e);
      if (!m_busy) begin
         for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (r[i]) begin
               m_busy  = 1;
               m_owner = i;
               break;
            end
         end
      end else if (e.xfer && t[m_owner]) begin
         m_busy = 0;
         m_ptr  = (m_owner + 1) % NR;
      end
   endtask

   // Asynchronous reset pulse in the middle of a cycle, held over the next edge.
   task automatic do_reset();
      exp_t e;
      @(posedge CLK);
      #1;
      RSTn = 1'b0;
      #1;
      chk("rst_grt", 32'(GRT), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_owner", 32'(OWNER), 32'd0);
      chk("rst_xfer", 32'(XFER), 32'd0);
      m_busy = 0; m_owner = 0; m_ptr = 0;
      e = '0;
      sbq.push_back(e);
   endtask

   // Direct check against fixed spec vectors at the falling edge of this cycle.
   task automatic expect_now(input string name, input logic [NR-1:0] g, input int own, input logic x);
      @(negedge CLK);
      #1;
      chk({name, "_grt"}, 32'(GRT), 32'(g));
      chk({name, "_owner"}, 32'(OWNER), 32'(own));
      chk({name, "_xfer"}, 32'(XFER), 32'(x));
   endtask

   // Monitor: invariants every cycle, scoreboard compare whenever an entry is pending.
   always @(negedge CLK) begin
      exp_t e;
      chk("inv_onehot0", 32'($onehot0(GRT)), 32'd1);
      chk("inv_grt_busy", 32'(GRT != '0), 32'(BUSY));
      if (!BUSY) chk("inv_xfer_idle", 32'(XFER), 32'd0);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("sb_grt", 32'(GRT), 32'(e.grt));
         chk("sb_owner", 32'(OWNER), 32'(e.owner));
         chk("sb_busy", 32'(BUSY), 32'(e.busy));
         chk("sb_xfer", 32'(XFER), 32'(e.xfer));
      end
   end

   initial begin
      #2;
      chk("por_grt", 32'(GRT), 32'd0);
      chk("por_busy", 32'(BUSY), 32'd0);

      // single-flit packets from 2 then 4
      step(5'b10100, 5'b11111, 1'b1);
      step(5'b10100, 5'b11111, 1'b1);
      expect_now("v030_a", 5'b00100, 2, 1'b1);
      step(5'b10100, 5'b11111, 1'b1);
      step(5'b10100, 5'b11111, 1'b1);
      expect_now("v030_b", 5'b10000, 4, 1'b1);

      // all-request fairness
      do_reset();
      for (int n = 0; n < 12; n++) step(5'b11111, 5'b11111, 1'b1);

      // owner 1, 3 flits with credit stalls
      do_reset();
      step(5'b00010, 5'b00000, 1'b1);
      step(5'b00010, 5'b00000, 1'b1);
      step(5'b00010, 5'b00000, 1'b0);
      step(5'b00010, 5'b00000, 1'b1);
      step(5'b00010, 5'b00010, 1'b0);
      expect_now("v032_stall", 5'b00010, 1, 1'b0);
      step(5'b00010, 5'b00010, 1'b1);
      step(5'b00000, 5'b00000, 1'b1);

      // owner 4 holds while its request drops; pointer wraps to 0
      do_reset();
      step(5'b10000, 5'b00000, 1'b1);
      step(5'b00001, 5'b00000, 1'b1);
      step(5'b00001, 5'b00000, 1'b1);
      expect_now("v033_hold", 5'b10000, 4, 1'b0);
      step(5'b10001, 5'b10000, 1'b1);
      step(5'b10001, 5'b00000, 1'b1);
      step(5'b10001, 5'b00001, 1'b1);
      expect_now("v033_wrap", 5'b00001, 0, 1'b1);
      step(5'b00000, 5'b00000, 1'b1);

      // reset mid-packet with owner 3, then restart from pointer 0
      do_reset();
      step(5'b01000, 5'b00000, 1'b1);
      step(5'b01000, 5'b00000, 1'b1);
      do_reset();
      step(5'b11000, 5'b00000, 1'b0);
      step(5'b11000, 5'b00000, 1'b0);
      expect_now("v034", 5'b01000, 3, 1'b0);

      // randomized traffic
      for (int n = 0; n < 700; n++) begin
         logic [NR-1:0] r;
         logic [NR-1:0] t;
         logic          c;
         if ($urandom_range(0, 120) == 0) begin
            do_reset();
         end else begin
            r = NR'($urandom);
            if ($urandom_range(0, 5) == 0) r = '0;
            t = NR'($urandom) & NR'($urandom);
            c = ($urandom_range(0, 3) != 0);
            step(r, t, c);
         end
      end

      @(posedge CLK);
      @(negedge CLK);
      #1;
      chk("queue_drained", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
